// File: rtl/clk_div_meter.sv
// Dual-edge measurement receiver for divided clocks: high/low/period in clk half-cycles.
// Optional macro CLK_DIV_METER_SYNC_EN adds 2-flop synchronizers on both sample paths.
module clk_div_meter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_DIV  = 9,
  parameter int unsigned DUTY_TOL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             div_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_hc,
  output logic [CNT_W-1:0] low_hc,
  output logic [CNT_W:0]   period_hc,
  output logic             duty_ok,
  output logic             div_match,
  output logic             err
);

  localparam int unsigned PER_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_cnt, high_d;
  logic [CNT_W-1:0] low_cnt, low_d;
  logic [CNT_W-1:0] idle_cnt, idle_d;
  logic [CNT_W-1:0] res_high, res_low;
  logic [PER_W-1:0] res_per, res_diff;
  logic             valid_d, err_d;
  logic             n_in, p_in;
  logic             s_n, s_n_r, s_p, prev_s;
  logic             cur, prv;

`ifdef CLK_DIV_METER_SYNC_EN
  logic [1:0] n_sync, p_sync;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) n_sync <= '0;
    else       n_sync <= {n_sync[0], div_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) p_sync <= '0;
    else       p_sync <= {p_sync[0], div_in};
  end

  assign n_in = n_sync[1];
  assign p_in = p_sync[1];
`else
  assign n_in = div_in;
  assign p_in = div_in;
`endif

  // Negedge sample; retimed to posedge so the pair {s_n_r, s_p} is in time order
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) s_n <= 1'b0;
    else       s_n <= n_in;
  end

  assign res_per  = PER_W'(res_high) + PER_W'(res_low);
  assign res_diff = (res_high >= res_low) ? PER_W'(res_high - res_low)
                                          : PER_W'(res_low - res_high);

  // Next state: walk the two half-cycle samples of the pair in time order
  always_comb begin
    state_d  = state_q;
    high_d   = high_cnt;
    low_d    = low_cnt;
    idle_d   = idle_cnt;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    res_high = high_cnt;
    res_low  = low_cnt;
    prv      = prev_s;
    cur      = 1'b0;
    if (!en) begin
      state_d = IDLE;
      high_d  = '0;
      low_d   = '0;
      idle_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = SYNC;
      high_d  = '0;
      low_d   = '0;
      idle_d  = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cur = (i == 0) ? s_n_r : s_p;
        case (state_d)
          SYNC: begin
            if (!prv && cur) begin
              state_d = HIGH;
              high_d  = CNT_W'(1);
              low_d   = '0;
              idle_d  = '0;
            end else if (idle_d == CNT_MAX) begin
              err_d  = 1'b1;
              idle_d = '0;
            end else begin
              idle_d = idle_d + CNT_W'(1);
            end
          end
          HIGH: begin
            if (cur && high_d == CNT_MAX) begin
              err_d   = 1'b1;
              state_d = SYNC;
              high_d  = '0;
              low_d   = '0;
              idle_d  = '0;
            end else if (cur) begin
              high_d = high_d + CNT_W'(1);
            end else begin
              state_d = LOW;
              low_d   = CNT_W'(1);
            end
          end
          LOW: begin
            if (!cur && low_d == CNT_MAX) begin
              err_d   = 1'b1;
              state_d = SYNC;
              high_d  = '0;
              low_d   = '0;
              idle_d  = '0;
            end else if (!cur) begin
              low_d = low_d + CNT_W'(1);
            end else begin
              valid_d  = 1'b1;
              res_high = high_d;
              res_low  = low_d;
              state_d  = HIGH;
              high_d   = CNT_W'(1);
              low_d    = '0;
            end
          end
          default: ;
        endcase
        prv = cur;
      end
    end
  end

  // State, counters, sample pipeline and registered results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      high_cnt   <= '0;
      low_cnt    <= '0;
      idle_cnt   <= '0;
      s_p        <= 1'b0;
      s_n_r      <= 1'b0;
      prev_s     <= 1'b0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      high_hc    <= '0;
      low_hc     <= '0;
      period_hc  <= '0;
      duty_ok    <= 1'b0;
      div_match  <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_cnt   <= high_d;
      low_cnt    <= low_d;
      idle_cnt   <= idle_d;
      s_p        <= p_in;
      s_n_r      <= s_n;
      prev_s     <= s_p;
      meas_valid <= valid_d;
      err        <= err_d;
      if (valid_d) begin
        high_hc   <= res_high;
        low_hc    <= res_low;
        period_hc <= res_per;
        duty_ok   <= (res_diff <= PER_W'(DUTY_TOL));
        div_match <= (res_per == PER_W'(2 * EXP_DIV));
      end
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// Randomized/directed bench for clk_div_meter against an edge-timestamp reference model.
module tb_clk_div_meter;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned EXP_DIV  = 9;
  localparam int unsigned DUTY_TOL = 0;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             div_in = 1'b0;
  logic             meas_valid, duty_ok, div_match, err;
  logic [CNT_W-1:0] high_hc, low_hc;
  logic [CNT_W:0]   period_hc;

  clk_div_meter #(.CNT_W(CNT_W), .EXP_DIV(EXP_DIV), .DUTY_TOL(DUTY_TOL)) dut (
    .clk(clk), .rstn(rstn), .en(en), .div_in(div_in),
    .meas_valid(meas_valid), .high_hc(high_hc), .low_hc(low_hc),
    .period_hc(period_hc), .duty_ok(duty_ok), .div_match(div_match), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int hi; int lo; int per; int duty; int match; int cyc;} res_t;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   wave[$];
  bit   pat[$];
  res_t obs_q[$];
  res_t exp_q[$];
  int   err_cyc_q[$];
  res_t mon_r;

  task automatic check(input string tag, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // One waveform value per half-cycle, changed just after every clk edge
  initial forever begin
    @(clk);
    #1;
    div_in = (wave.size() > 0) ? wave.pop_front() : 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) begin
      mon_r.hi    = int'(high_hc);
      mon_r.lo    = int'(low_hc);
      mon_r.per   = int'(period_hc);
      mon_r.duty  = int'(duty_ok);
      mon_r.match = int'(div_match);
      mon_r.cyc   = cyc;
      obs_q.push_back(mon_r);
    end
    if (err) err_cyc_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void add_phase(bit v, int n);
    repeat (n) pat.push_back(v);
  endfunction

  // Reference: each rising edge after a rise/fall pair closes one period
  function automatic void build_expect();
    bit prev = 1'b0;
    int rise = -1;
    int fall = -1;
    exp_q.delete();
    foreach (pat[i]) begin
      if (!prev && pat[i]) begin
        if (rise >= 0 && fall > rise) begin
          res_t e;
          int   d;
          e.hi    = fall - rise;
          e.lo    = i - fall;
          e.per   = e.hi + e.lo;
          d       = (e.hi > e.lo) ? e.hi - e.lo : e.lo - e.hi;
          e.duty  = (d <= int'(DUTY_TOL)) ? 1 : 0;
          e.match = (e.per == int'(2 * EXP_DIV)) ? 1 : 0;
          e.cyc   = 0;
          exp_q.push_back(e);
        end
        rise = i;
      end
      if (prev && !pat[i] && rise >= 0) fall = i;
      prev = pat[i];
    end
  endfunction

  task automatic check_res(input string tag, input res_t o, input res_t e);
    check({tag, "_hi"},    o.hi,    e.hi);
    check({tag, "_lo"},    o.lo,    e.lo);
    check({tag, "_per"},   o.per,   e.per);
    check({tag, "_duty"},  o.duty,  e.duty);
    check({tag, "_match"}, o.match, e.match);
  endtask

  task automatic run_pat(input string tag);
    int budget;
    build_expect();
    obs_q.delete();
    @(negedge clk);
    en = 1'b1;
    foreach (pat[i]) wave.push_back(pat[i]);
    budget = pat.size() + 100;
    while (wave.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check({tag, "_drain"}, int'(wave.size()), 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < obs_q.size()) check_res($sformatf("%s_%0d", tag, k), obs_q[k], exp_q[k]);
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    while (obs_q.size() < n && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    check({tag, "_arrived"}, (obs_q.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(meas_valid), 0);
    check({tag, "_err"},   int'(err), 0);
    check({tag, "_hi"},    int'(high_hc), 0);
    check({tag, "_lo"},    int'(low_hc), 0);
    check({tag, "_per"},   int'(period_hc), 0);
    check({tag, "_duty"},  int'(duty_ok), 0);
    check({tag, "_match"}, int'(div_match), 0);
  endtask

  res_t nine;
  int   v0, n0, rel, gap;

  initial begin
    nine.hi = 9; nine.lo = 9; nine.per = 18; nine.duty = 1; nine.match = 1; nine.cyc = 0;

    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // div_in stuck low: periodic timeout, no results
    obs_q.delete();
    err_cyc_q.delete();
    @(negedge clk);
    en = 1'b1;
    repeat (700) @(posedge clk);
    #2;
    check("stuck_err_count", (err_cyc_q.size() >= 4) ? 1 : 0, 1);
    for (int k = 1; k < err_cyc_q.size(); k++)
      check($sformatf("stuck_err_gap%0d", k), err_cyc_q[k] - err_cyc_q[k-1], 128);
    check("stuck_valid_count", obs_q.size(), 0);
    check("stuck_hi", int'(high_hc), 0);
    check("stuck_per", int'(period_hc), 0);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);

    // Posedge-only /4
    pat.delete(); add_phase(0, 16);
    repeat (5) begin add_phase(1, 4); add_phase(0, 4); end
    add_phase(1, 4);
    run_pat("div4");

    // Posedge-only /9, 4 clk high, 5 clk low
    pat.delete(); add_phase(0, 16);
    repeat (5) begin add_phase(1, 8); add_phase(0, 10); end
    add_phase(1, 8);
    run_pat("div9asym");

    // Minimum 1-half-cycle phases
    pat.delete(); add_phase(0, 16);
    repeat (4) begin add_phase(1, 1); add_phase(0, 1); end
    add_phase(1, 1); add_phase(0, 2); add_phase(1, 2); add_phase(0, 1); add_phase(1, 1);
    run_pat("min1");

    // Largest measurable high phase
    pat.delete(); add_phase(0, 16);
    add_phase(1, 255); add_phase(0, 3); add_phase(1, 2);
    run_pat("max255");

    for (int r = 0; r < 6; r++) begin
      int np;
      np = int'($urandom_range(3, 7));
      pat.delete(); add_phase(0, 16);
      repeat (np) begin
        add_phase(1, int'($urandom_range(1, 30)));
        add_phase(0, int'($urandom_range(1, 30)));
      end
      add_phase(1, int'($urandom_range(1, 30)));
      run_pat($sformatf("rnd%0d", r));
    end

    // Dual-edge /9: result every 9 clk
    pat.delete(); add_phase(0, 16);
    repeat (8) begin add_phase(1, 9); add_phase(0, 9); end
    add_phase(1, 9);
    run_pat("dual9");
    for (int k = 1; k < obs_q.size(); k++)
      check($sformatf("dual9_gap%0d", k), obs_q[k].cyc - obs_q[k-1].cyc, 9);

    // Continuous /9 for en drop and reset tests
    pat.delete(); add_phase(0, 16);
    repeat (30) begin add_phase(1, 9); add_phase(0, 9); end
    obs_q.delete();
    @(negedge clk);
    en = 1'b1;
    foreach (pat[i]) wave.push_back(pat[i]);
    wait_obs(3, 200, "drop_pre");
    n0 = obs_q.size();
    v0 = obs_q[n0-1].cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_obs(n0 + 1, 60, "drop_post");
    if (obs_q.size() > n0) begin
      check("drop_gap", obs_q[n0].cyc - v0, 18);
      check_res("drop_res", obs_q[n0], nine);
    end

    // Reset during LOW
    wait_obs(obs_q.size() + 1, 40, "rst_pre");
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    rel = cyc;
    n0  = obs_q.size();
    wait_obs(n0 + 1, 40, "rst_post");
    if (obs_q.size() > n0) begin
      gap = obs_q[n0].cyc - rel;
      check("rst_gap_ok", (gap >= 9 && gap <= 30) ? 1 : 0, 1);
      check_res("rst_res", obs_q[n0], nine);
    end
    @(negedge clk);
    en = 1'b0;
    wave.delete();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
